// File: rtl/aes_link_pkg.sv
// Shared definitions for the 128-bit AES load link, used by both the transmit
// side and the loader side.
package aes_link_pkg;

  localparam int WORD_W = 128;
  localparam logic [WORD_W-1:0] ZERO_WORD = 128'h0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEP  = 3'd1,
    ST_KEY  = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } link_state_e;

  // Byte lane of a link word; lane 0 sits at bits [7:0].
  function automatic logic [7:0] byte_lane(input logic [WORD_W-1:0] word, input int unsigned lane);
    return word[8*lane +: 8];
  endfunction

  function automatic logic is_zero_word(input logic [WORD_W-1:0] word);
    return (word == ZERO_WORD);
  endfunction

endpackage

// File: rtl/aes_frame_buf.sv
// Two-entry FIFO of pending frames, each entry packed as {key, pt}.
module aes_frame_buf
  import aes_link_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [2*WORD_W-1:0]   din,
  input  logic                  pop,
  output logic [2*WORD_W-1:0]   dout,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [2*WORD_W-1:0] mem_r [2];
  logic                wr_ptr_r;
  logic                rd_ptr_r;
  logic [1:0]          count_r;
  logic                do_push_s;
  logic                do_pop_s;

  // Overflowing pushes and underflowing pops are ignored.
  always_comb begin
    do_push_s = push && (count_r != 2'd2);
    do_pop_s  = pop && (count_r != 2'd0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign count = count_r;

endmodule

// File: rtl/aes_frame_tx.sv
// Transmit side of the AES load link: buffers requests and serialises each one
// as zero separators, one key word and a held plaintext word.
module aes_frame_tx
  import aes_link_pkg::*;
#(
  parameter int SEP_CYCLES  = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_key,
  input  logic [WORD_W-1:0] req_pt,
  output logic [WORD_W-1:0] out,
  output logic              busy,
  output logic              frame_done,
  output logic              err_zero
);

  localparam int SEP_EFF  = (SEP_CYCLES < 1) ? 1 : SEP_CYCLES;
  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_EFF  = (GAP_CYCLES < 0) ? 0 : GAP_CYCLES;
  localparam int MAX_SH   = (SEP_EFF > HOLD_EFF) ? SEP_EFF : HOLD_EFF;
  localparam int MAX_ALL  = (MAX_SH > GAP_EFF) ? MAX_SH : GAP_EFF;
  localparam int CNT_W    = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SEP_LOAD  = CNT_W'(SEP_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_EFF > 0) ? GAP_EFF - 1 : 0);

  link_state_e         state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [WORD_W-1:0]   out_r, word_s;
  logic                ready_r, busy_r, done_r, err_r;
  logic                accept_s, bad_s, push_s, pop_s, more_s;
  logic                full_s, empty_s;
  logic [1:0]          count_s, count_n_s;
  logic [2*WORD_W-1:0] head_s;

  aes_frame_buf u_buf (
    .clock  (clock),
    .resetn (resetn),
    .push   (push_s),
    .din    ({req_key, req_pt}),
    .pop    (pop_s),
    .dout   (head_s),
    .full   (full_s),
    .empty  (empty_s),
    .count  (count_s)
  );

  // Zero-valued requests are accepted but never stored: they cannot be sent in-band.
  always_comb begin
    accept_s = req_valid && ready_r;
    bad_s    = is_zero_word(req_key) || is_zero_word(req_pt);
    push_s   = accept_s && !bad_s && !full_s;
    more_s   = (count_s > 2'd1) || push_s;
  end

  // Phase sequencing; the single down-counter is reloaded on every state entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_s = ST_SEP;
          cnt_s   = SEP_LOAD;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      ST_SEP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_KEY;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_KEY: begin
        state_s = ST_DATA;
        cnt_s   = HOLD_LOAD;
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          pop_s = 1'b1;
          if (GAP_EFF > 0) begin
            state_s = ST_GAP;
            cnt_s   = GAP_LOAD;
          end else if (more_s) begin
            state_s = ST_SEP;
            cnt_s   = SEP_LOAD;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          if (!empty_s) begin
            state_s = ST_SEP;
            cnt_s   = SEP_LOAD;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Word for the upcoming cycle and the buffer occupancy after this edge.
  always_comb begin
    count_n_s = count_s + {1'b0, push_s} - {1'b0, pop_s};
    word_s    = ZERO_WORD;
    case (state_s)
      ST_KEY:  word_s = head_s[2*WORD_W-1:WORD_W];
      ST_DATA: word_s = head_s[WORD_W-1:0];
      default: word_s = ZERO_WORD;
    endcase
  end

  // State, counter and every output are registered; reset forces a zero word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      out_r   <= ZERO_WORD;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      out_r   <= word_s;
      ready_r <= (count_n_s < 2'd2);
      busy_r  <= (state_s != ST_IDLE) || (count_n_s != 2'd0);
      done_r  <= (state_s == ST_DATA) && (cnt_s == CNT_ZERO);
      err_r   <= accept_s && bad_s;
    end
  end

  assign out        = out_r;
  assign req_ready  = ready_r;
  assign busy       = busy_r;
  assign frame_done = done_r;
  assign err_zero   = err_r;

endmodule

// File: tb/tb_aes_frame_tx.sv
// Scoreboard bench for aes_frame_tx: default instance plus a SEP=1/HOLD=1/GAP=0
// instance, both observed through a loader model that rebuilds key and block.
module tb_aes_frame_tx;
  import aes_link_pkg::*;

  localparam int SEP0 = 2, HOLD0 = 2, GAP0 = 3;
  localparam int SEP1 = 1, HOLD1 = 1, GAP1 = 0;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic v0 = 1'b0, r0, busy0, fd0, ez0;
  logic v1 = 1'b0, r1, busy1, fd1, ez1;
  logic [127:0] k0 = '0, p0 = '0, o0;
  logic [127:0] k1 = '0, p1 = '0, o1;

  aes_frame_tx #(.SEP_CYCLES(SEP0), .HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAP0)) u_dut (
    .clock(clock), .resetn(resetn), .req_valid(v0), .req_ready(r0), .req_key(k0),
    .req_pt(p0), .out(o0), .busy(busy0), .frame_done(fd0), .err_zero(ez0));

  aes_frame_tx #(.SEP_CYCLES(SEP1), .HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1)) u_dut_fast (
    .clock(clock), .resetn(resetn), .req_valid(v1), .req_ready(r1), .req_key(k1),
    .req_pt(p1), .out(o1), .busy(busy1), .frame_done(fd1), .err_zero(ez1));

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
  } frame_t;

  frame_t frame_q [2][$];
  int     err_q   [2][$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;

  // Loader model state per instance.
  int         zrun  [2];
  int         nzrun [2];
  bit         had_frame [2];
  bit         exact [2];
  logic [7:0] ld_k [2][16];
  logic [7:0] ld_g [2][16];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void drive(input int d, input logic v, input logic [127:0] k, input logic [127:0] p);
    if (d == 0) begin
      v0 = v; k0 = k; p0 = p;
    end else begin
      v1 = v; k1 = k; p1 = p;
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Loader: a zero word starts a frame, the first nonzero word is the key,
  // later nonzero words are the block.
  function automatic void monitor_step(input int d);
    logic [127:0] w, kw, gw;
    logic         fd, ez, bz;
    int           hold, minz, ecyc;
    frame_t       e;
    w    = (d == 0) ? o0 : o1;
    fd   = (d == 0) ? fd0 : fd1;
    ez   = (d == 0) ? ez0 : ez1;
    bz   = (d == 0) ? busy0 : busy1;
    hold = (d == 0) ? HOLD0 : HOLD1;
    minz = (d == 0) ? (GAP0 + SEP0) : (GAP1 + SEP1);
    if (!resetn) begin
      zrun[d] = 0; nzrun[d] = 0; had_frame[d] = 1'b0; exact[d] = 1'b0;
      return;
    end
    if (w == ZERO_WORD) begin
      zrun[d]++;
      nzrun[d] = 0;
    end else begin
      check("busy_while_sending", bz, 1);
      if (nzrun[d] == 0) begin
        if (had_frame[d] && exact[d]) check("zero_run_exact", zrun[d], minz);
        else if (had_frame[d]) check("zero_run_min", (zrun[d] >= minz), 1);
        for (int i = 0; i < 16; i++) ld_k[d][i] = byte_lane(w, i);
      end else begin
        for (int i = 0; i < 16; i++) ld_g[d][i] = byte_lane(w, i);
      end
      nzrun[d]++;
      zrun[d] = 0;
      if (nzrun[d] > 1 + hold) check("nonzero_run_len", nzrun[d], 1 + hold);
    end
    if (fd) begin
      if (frame_q[d].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame_done: inst=%0d actual=pulse required=none", d);
      end else begin
        e = frame_q[d].pop_front();
        for (int i = 0; i < 16; i++) begin
          kw[8*i +: 8] = ld_k[d][i];
          gw[8*i +: 8] = ld_g[d][i];
        end
        check("loader_key", kw, e.key);
        check("loader_block", gw, e.pt);
        check("frame_word_count", nzrun[d], 1 + hold);
      end
      had_frame[d] = 1'b1;
      exact[d] = (frame_q[d].size() != 0);
    end
    if (ez) begin
      if (err_q[d].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_err_zero: inst=%0d actual=pulse required=none", d);
      end else begin
        ecyc = err_q[d].pop_front();
        check("err_zero_cycle", cyc, ecyc);
      end
    end
  endfunction

  initial forever begin
    @(negedge clock);
    for (int d = 0; d < 2; d++) monitor_step(d);
  end

  // Issue one request; the expectation is queued on the accepting edge.
  task automatic send(input int d, input logic [127:0] k, input logic [127:0] p);
    int guard = 0;
    drive(d, 1'b1, k, p);
    while (((d == 0) ? r0 : r1) !== 1'b1 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: inst=%0d actual=not ready required=ready", d);
      drive(d, 1'b0, '0, '0);
      return;
    end
    @(posedge clock); #1;
    if (k == ZERO_WORD || p == ZERO_WORD) err_q[d].push_back(cyc);
    else frame_q[d].push_back({k, p});
    drive(d, 1'b0, '0, '0);
  endtask

  task automatic wait_idle(input int d);
    int guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while ((frame_q[d].size() != 0 || err_q[d].size() != 0 ||
                ((d == 0) ? busy0 : busy1) !== 1'b0) && guard < 1000);
    check("drain_in_budget", (guard < 1000), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t1_w [7];
    logic         t1_fd [7];
    logic [127:0] key1, pt1, k, p;
    bit           found;

    repeat (3) @(posedge clock);
    #1;
    check("reset_out", o0, 0);
    check("reset_ready", r0, 0);
    check("reset_busy", busy0, 0);
    check("reset_done", fd0, 0);
    check("reset_err", ez0, 0);
    @(negedge clock);
    resetn = 1'b1;
    check("ready_before_first_edge", r0, 0);
    @(posedge clock); #1;
    check("ready_after_first_edge", r0, 1);
    check("ready_after_first_edge_fast", r1, 1);

    // Directed frame with byte 0 = 00 in lane [7:0].
    key1 = 128'h0f0e0d0c0b0a09080706050403020100;
    pt1  = 128'hffeeddccbbaa99887766554433221100;
    t1_w  = '{ZERO_WORD, ZERO_WORD, ZERO_WORD, key1, pt1, pt1, ZERO_WORD};
    t1_fd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    send(0, key1, pt1);
    for (int j = 0; j < 7; j++) begin
      @(negedge clock);
      check("t1_out", o0, t1_w[j]);
      check("t1_frame_done", fd0, t1_fd[j]);
    end
    wait_idle(0);

    // Three back-to-back requests; the buffer fills after the second.
    send(0, rand128(), rand128());
    send(0, rand128(), rand128());
    check("t2_ready_drops", r0, 0);
    send(0, rand128(), rand128());
    wait_idle(0);

    // Zero plaintext is rejected and nothing reaches the bus.
    send(0, rand128(), ZERO_WORD);
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      check("t3_out_zero", o0, 0);
      check("t3_busy_low", busy0, 0);
    end
    send(0, rand128(), rand128());
    wait_idle(0);

    // Reset during the plaintext phase.
    k = rand128();
    p = rand128();
    send(0, k, p);
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      @(negedge clock);
      if (o0 === p) found = 1'b1;
    end
    check("t4_reached_data", found, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t4_out_async_zero", o0, 0);
    check("t4_busy_in_reset", busy0, 0);
    frame_q[0].delete();
    frame_q[1].delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("t4_busy_after_release", busy0, 0);
    check("t4_ready_after_release", r0, 1);
    send(0, rand128(), rand128());
    wait_idle(0);

    // Randomised traffic including zero-word requests.
    for (int n = 0; n < 24; n++) begin
      k = rand128();
      p = rand128();
      case ($urandom_range(0, 7))
        0: k = ZERO_WORD;
        1: p = ZERO_WORD;
        default: ;
      endcase
      send(0, k, p);
      repeat ($urandom_range(0, 6)) @(posedge clock);
      #1;
    end
    wait_idle(0);

    // SEP=1, HOLD=1, GAP=0: back-to-back frames separated by one zero word.
    send(1, rand128(), rand128());
    send(1, rand128(), rand128());
    send(1, rand128(), rand128());
    wait_idle(1);
    check("t6_frames_sent", frame_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
